// File: rtl/neuron_pkg.sv
// Shared types and helpers for the MLP neuron datapath.
package neuron_pkg;

  typedef enum logic {ACT_LINEAR = 1'b0, ACT_RELU = 1'b1} act_mode_e;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  localparam int DEFAULT_FRAC_BITS = 12;
  localparam int SAT_W = 128;

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [SAT_W-1:0] sat_to_width(input logic signed [SAT_W-1:0] val,
                                                           input int dw);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    min_v = ~max_v;
    if (val > max_v)      return max_v;
    else if (val < min_v) return min_v;
    else                  return val;
  endfunction

endpackage

// File: rtl/neuron_sat_act.sv
// Combinational post-process: fixed-point rescale (floor), saturate or wrap, overflow flag, ReLU.
module neuron_sat_act
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int ACC_WIDTH  = 35,
  parameter bit SATURATE   = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  act_mode_e                    act_mode,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         overflow
);

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [SAT_W-1:0]      s_ext;
  logic signed [SAT_W-1:0]      clamped;
  logic signed [DATA_WIDTH-1:0] pre;

  always_comb begin
    shifted  = acc >>> FRAC_BITS;
    s_ext    = {{(SAT_W-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
    clamped  = sat_to_width(s_ext, DATA_WIDTH);
    overflow = (clamped != s_ext);
    pre      = SATURATE ? clamped[DATA_WIDTH-1:0] : s_ext[DATA_WIDTH-1:0];
    // ReLU applies after saturation and leaves the overflow flag untouched.
    result   = (act_mode == ACT_RELU && pre[DATA_WIDTH-1]) ? '0 : pre;
  end

endmodule

// File: rtl/mac_neuron.sv
// Sequential MLP neuron: bias + sum(x*w) with one shared multiplier, then saturate/activate.
// Result NUM_INPUTS cycles after accept; held until out_ready, inputs refused while busy.
module mac_neuron
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] inputs  [NUM_INPUTS],
  input  logic signed [DATA_WIDTH-1:0] weights [NUM_INPUTS],
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         act_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] neuron_out,
  output logic                         overflow
);

  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(NUM_INPUTS+1) + 1;
  localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PROD_W    = 2*DATA_WIDTH;

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] x_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] x_d [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] w_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] w_d [NUM_INPUTS];
  act_mode_e                    mode_q, mode_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         ovf_q, ovf_d;
  logic signed [PROD_W-1:0]     prod;
  logic signed [DATA_WIDTH-1:0] post_res;
  logic                         post_ovf;

  // Post-process sees the accumulator value including the current product.
  neuron_sat_act #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH),
    .SATURATE   (SATURATE)
  ) u_sat_act (
    .acc      (acc_sum),
    .act_mode (mode_q),
    .result   (post_res),
    .overflow (post_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    x_d      = x_q;
    w_d      = w_q;
    mode_d   = mode_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    in_ready = (state_q == IDLE) && !rst;
    prod     = x_q[idx_q] * w_q[idx_q];
    acc_sum  = acc_q + $signed({{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod});

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = inputs;
          w_d     = weights;
          mode_d  = act_mode_e'(act_mode);
          acc_d   = $signed({{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< FRAC_BITS;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_INPUTS-1)) begin
          out_d   = post_res;
          ovf_d   = post_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '{default: '0};
      w_q     <= '{default: '0};
      mode_q  <= ACT_LINEAR;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign neuron_out = out_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_neuron.sv
// Directed bench: saturating and wrapping N=2 neurons side by side, plus an N=4 neuron for abort.
module tb_mac_neuron;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0, act_mode = 1'b0, out_ready = 1'b1;
  logic signed [15:0] x_in [2];
  logic signed [15:0] w_in [2];
  logic signed [15:0] b_in = '0;
  logic               in_ready, out_valid, overflow;
  logic               in_ready_w, out_valid_w, overflow_w;
  logic signed [15:0] nout, nout_w;

  logic               in_valid4 = 1'b0, act_mode4 = 1'b0, out_ready4 = 1'b1;
  logic signed [15:0] x4 [4];
  logic signed [15:0] w4 [4];
  logic signed [15:0] b4 = '0;
  logic               in_ready4, out_valid4, overflow4;
  logic signed [15:0] nout4;

  int n_chk = 0;
  int n_fail = 0;

  mac_neuron #(.NUM_INPUTS(2), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inputs(x_in), .weights(w_in),
    .bias(b_in), .act_mode(act_mode), .out_valid(out_valid), .out_ready(out_ready),
    .neuron_out(nout), .overflow(overflow));

  mac_neuron #(.NUM_INPUTS(2), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .inputs(x_in), .weights(w_in),
    .bias(b_in), .act_mode(act_mode), .out_valid(out_valid_w), .out_ready(out_ready),
    .neuron_out(nout_w), .overflow(overflow_w));

  mac_neuron #(.NUM_INPUTS(4), .SATURATE(1'b1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .inputs(x4), .weights(w4),
    .bias(b4), .act_mode(act_mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .neuron_out(nout4), .overflow(overflow4));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input bit four, input int lat);
    int cyc = 0;
    while (!(four ? out_valid4 : out_valid) && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 16'(cyc), 16'(lat));
  endtask

  task automatic run2(input string tag, input logic [15:0] x0, x1, w0, w1, b, input logic mode,
                      input logic [15:0] exp_s, input logic exp_ovf, input logic [15:0] exp_w);
    x_in[0] = x0; x_in[1] = x1; w_in[0] = w0; w_in[1] = w1; b_in = b; act_mode = mode;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    wait_out(tag, 1'b0, 2);
    check({tag, "_out"}, nout, exp_s);
    check({tag, "_ovf"}, 16'(overflow), 16'(exp_ovf));
    check({tag, "_out_wrap"}, nout_w, exp_w);
    check({tag, "_ovf_wrap"}, 16'(overflow_w), 16'(exp_ovf));
    tick();
    check({tag, "_valid_drop"}, 16'(out_valid), 16'h0);
  endtask

  task automatic run4(input string tag);
    x4 = '{16'h1000, 16'h2000, 16'hF000, 16'h0800};
    w4 = '{16'h1000, 16'h1000, 16'h1000, 16'h2000};
    b4 = 16'h0400;
    in_valid4 = 1'b1;
    check({tag, "_in_ready"}, 16'(in_ready4), 16'h1);
    tick();
    in_valid4 = 1'b0;
    wait_out(tag, 1'b1, 4);
    check({tag, "_out"}, nout4, 16'h3400);
    check({tag, "_ovf"}, 16'(overflow4), 16'h0);
    tick();
  endtask

  initial begin
    x_in = '{16'h0, 16'h0};
    w_in = '{16'h0, 16'h0};
    x4 = '{default: '0};
    w4 = '{default: '0};

    // Reset state, in_ready low while rst is asserted.
    tick(); tick();
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_neuron_out", nout, 16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 16'(in_ready), 16'h1);

    run2("t1_basic", 16'h1000, 16'h1000, 16'h1000, 16'hF000, 16'h0800, 1'b0, 16'h0800, 1'b0, 16'h0800);
    run2("t2_big", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 16'hFFE0);
    run2("t3_lin", 16'h1000, 16'h0000, 16'hE000, 16'h1000, 16'h0000, 1'b0, 16'hE000, 1'b0, 16'hE000);
    run2("t3_relu", 16'h1000, 16'h0000, 16'hE000, 16'h1000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000);
    run2("t4_floor", 16'h0001, 16'h0000, 16'hF000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF);
    check("t4_retain", nout, 16'hFFFF);

    // Backpressure: result held while a new set waits.
    out_ready = 1'b0;
    x_in = '{16'h1000, 16'h1000}; w_in = '{16'h1000, 16'hF000}; b_in = 16'h0800; act_mode = 1'b0;
    in_valid = 1'b1;
    tick();
    x_in = '{16'h0001, 16'h0000}; w_in = '{16'hF000, 16'h0000}; b_in = 16'h0000;
    wait_out("t5_first", 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", 16'(out_valid), 16'h1);
      check("t5_hold_out", nout, 16'h0800);
      check("t5_hold_in_ready", 16'(in_ready), 16'h0);
    end
    out_ready = 1'b1;
    tick();
    check("t5_after_hs_valid", 16'(out_valid), 16'h0);
    check("t5_after_hs_in_ready", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    check("t5_accepted", 16'(in_ready), 16'h0);
    wait_out("t5_second", 1'b0, 2);
    check("t5_second_out", nout, 16'hFFFF);
    tick();

    // Abort mid-transaction on the N=4 neuron.
    run4("t6_pre");
    x4 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    w4 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_abort_valid", 16'(out_valid4), 16'h0);
    check("t6_abort_out", nout4, 16'h0);
    check("t6_abort_ovf", 16'(overflow4), 16'h0);
    check("t6_abort_in_ready", 16'(in_ready4), 16'h0);
    rst = 1'b0;
    #1;
    check("t6_rel_in_ready", 16'(in_ready4), 16'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_no_result", 16'(out_valid4), 16'h0);
    end
    run4("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
